// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction fetch path (IF) and
// the load/store path (DM). One access is in flight at a time. Read data is
// captured after a fixed memory latency and returned with a one-cycle valid
// pulse. Stores complete one cycle after their grant.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    // fetch port (read only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    // memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Counter must hold MEM_LATENCY-1; sized so MEM_LATENCY=1 still gets one bit.
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_gnt_dm_q;   // 1: most recent grant went to DM
    logic              owner_dm_q;      // requester that owns the read in flight
    logic              if_gnt_q;
    logic              dm_gnt_q;
    logic              if_valid_q;
    logic              dm_valid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_wr_q;

    logic              any_req_d;
    logic              grant_dm_d;

    // Winner selection: a lone requester wins; on a tie the side not granted
    // last time wins, so neither side ever waits for more than one foreign access.
    always_comb begin
        any_req_d  = if_req | dm_req;
        grant_dm_d = dm_req & (~if_req | ~last_gnt_dm_q);
    end

    // Access FSM; every output is a register driven from here.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            last_gnt_dm_q <= 1'b1;          // first tie after reset goes to IF
            owner_dm_q    <= 1'b0;
            if_gnt_q      <= 1'b0;
            dm_gnt_q      <= 1'b0;
            if_valid_q    <= 1'b0;
            dm_valid_q    <= 1'b0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wr_q      <= 1'b0;
        end else begin
            // grant and valid are single-cycle pulses
            if_gnt_q   <= 1'b0;
            dm_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        last_gnt_dm_q <= grant_dm_d;
                        owner_dm_q    <= grant_dm_d;
                        if (grant_dm_d) begin
                            dm_gnt_q   <= 1'b1;
                            mem_addr_q <= dm_addr;
                            if (dm_wr) begin
                                mem_wdata_q <= dm_wdata;
                                mem_wr_q    <= 1'b1;
                                state_q     <= S_WRITE;
                            end else begin
                                cnt_q   <= CNT_INIT;
                                state_q <= S_RD_WAIT;
                            end
                        end else begin
                            if_gnt_q   <= 1'b1;
                            mem_addr_q <= if_addr;
                            cnt_q      <= CNT_INIT;
                            state_q    <= S_RD_WAIT;
                        end
                    end
                end

                S_RD_WAIT: begin
                    // counter reaches zero exactly MEM_LATENCY edges after launch
                    if (cnt_q == '0) begin
                        if (owner_dm_q) begin
                            dm_rdata_q <= mem_rdata;
                            dm_valid_q <= 1'b1;
                        end else begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_WRITE: begin
                    // the write strobe has been high for exactly one cycle
                    mem_wr_q   <= 1'b0;
                    dm_valid_q <= 1'b1;
                    state_q    <= S_IDLE;
                end

                default: begin
                    mem_wr_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = if_gnt_q;
    assign dm_gnt    = dm_gnt_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench: one arbiter with MEM_LATENCY=2 (memory model with one
// register stage) and one with MEM_LATENCY=1 (combinational memory model).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- DUT A, latency 2 ----------------
    logic        if_req_a = 1'b0, dm_req_a = 1'b0, dm_wr_a = 1'b0;
    logic [31:0] if_addr_a = '0, dm_addr_a = '0, dm_wdata_a = '0;
    logic        if_gnt_a, if_valid_a, dm_gnt_a, dm_valid_a, mem_wr_a, busy_a;
    logic [31:0] if_rdata_a, dm_rdata_a, mem_addr_a, mem_wdata_a;
    logic [31:0] mem_rdata_a = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2)) dut_a (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_gnt(if_gnt_a),
        .if_valid(if_valid_a), .if_rdata(if_rdata_a),
        .dm_req(dm_req_a), .dm_wr(dm_wr_a), .dm_addr(dm_addr_a),
        .dm_wdata(dm_wdata_a), .dm_gnt(dm_gnt_a), .dm_valid(dm_valid_a),
        .dm_rdata(dm_rdata_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wr(mem_wr_a),
        .mem_rdata(mem_rdata_a), .busy(busy_a)
    );

    // ---------------- DUT B, latency 1 ----------------
    logic        if_req_b = 1'b0, dm_req_b = 1'b0, dm_wr_b = 1'b0;
    logic [31:0] if_addr_b = '0, dm_addr_b = '0, dm_wdata_b = '0;
    logic        if_gnt_b, if_valid_b, dm_gnt_b, dm_valid_b, mem_wr_b, busy_b;
    logic [31:0] if_rdata_b, dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_b (
        .Clk(Clk), .Reset(Reset),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_gnt(if_gnt_b),
        .if_valid(if_valid_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req_b), .dm_wr(dm_wr_b), .dm_addr(dm_addr_b),
        .dm_wdata(dm_wdata_b), .dm_gnt(dm_gnt_b), .dm_valid(dm_valid_b),
        .dm_rdata(dm_rdata_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wr(mem_wr_b),
        .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    // ---------------- memory models ----------------
    // Fixed contents plus one writable word (enough for the single store test).
    logic        wr_valid = 1'b0;
    logic [5:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;

    function automatic logic [31:0] rom_word(input logic [5:0] idx);
        case (idx)
            6'd0:    rom_word = 32'h2008_0005;
            6'd2:    rom_word = 32'h0000_1234;
            default: rom_word = 32'hC0DE_0000 | {26'd0, idx};
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [5:0] idx);
        mem_word = (wr_valid && wr_idx == idx) ? wr_data : rom_word(idx);
    endfunction

    always @(posedge Clk) begin
        mem_rdata_a <= mem_word(mem_addr_a[7:2]);
        if (mem_wr_a) begin
            wr_valid <= 1'b1;
            wr_idx   <= mem_addr_a[7:2];
            wr_data  <= mem_wdata_a;
        end
    end

    assign mem_rdata_b = rom_word(mem_addr_b[7:2]);

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Single read on DUT A, called on a falling edge; grant after E0, valid after E0+2.
    task automatic read_a(input logic is_dm, input logic [31:0] addr, input logic [31:0] exp, input string tag);
        if (is_dm) begin dm_req_a = 1'b1; dm_wr_a = 1'b0; dm_addr_a = addr; end
        else       begin if_req_a = 1'b1; if_addr_a = addr; end
        @(negedge Clk);
        check_eq({tag, " gnt"},   32'(is_dm ? dm_gnt_a : if_gnt_a), 32'd1);
        check_eq({tag, " ogn"},   32'(is_dm ? if_gnt_a : dm_gnt_a), 32'd0);
        check_eq({tag, " addr"},  mem_addr_a, addr);
        check_eq({tag, " busy"},  32'(busy_a), 32'd1);
        if_req_a = 1'b0; dm_req_a = 1'b0;
        @(negedge Clk);
        check_eq({tag, " vlo"},   32'(is_dm ? dm_valid_a : if_valid_a), 32'd0);
        @(negedge Clk);
        check_eq({tag, " valid"}, 32'(is_dm ? dm_valid_a : if_valid_a), 32'd1);
        check_eq({tag, " data"},  is_dm ? dm_rdata_a : if_rdata_a, exp);
        check_eq({tag, " idle"},  32'(busy_a), 32'd0);
        $display("read  %s port=%s addr=%08h data=%08h", tag, is_dm ? "DM" : "IF", addr,
                 is_dm ? dm_rdata_a : if_rdata_a);
        @(negedge Clk);
        check_eq({tag, " vdone"}, 32'(is_dm ? dm_valid_a : if_valid_a), 32'd0);
    endtask

    initial begin
        // ---- reset state, both requests already held ----
        if_req_a = 1'b1; if_addr_a = 32'h0;
        dm_req_a = 1'b1; dm_wr_a = 1'b0; dm_addr_a = 32'h8;
        repeat (2) @(negedge Clk);
        check_eq("rst if_gnt", 32'(if_gnt_a), 32'd0);
        check_eq("rst dm_gnt", 32'(dm_gnt_a), 32'd0);
        check_eq("rst busy",   32'(busy_a),   32'd0);
        check_eq("rst mem_wr", 32'(mem_wr_a), 32'd0);
        check_eq("rst maddr",  mem_addr_a,    32'd0);
        check_eq("rst if_rd",  if_rdata_a,    32'd0);
        check_eq("rst dm_rd",  dm_rdata_a,    32'd0);
        Reset = 1'b1;

        // ---- both held from reset: IF, DM, IF, DM every 3 cycles ----
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            check_eq($sformatf("tie if_gnt k%0d", k),   32'(if_gnt_a),   32'(k == 1 || k == 7));
            check_eq($sformatf("tie dm_gnt k%0d", k),   32'(dm_gnt_a),   32'(k == 4 || k == 10));
            check_eq($sformatf("tie if_valid k%0d", k), 32'(if_valid_a), 32'(k == 3 || k == 9));
            check_eq($sformatf("tie dm_valid k%0d", k), 32'(dm_valid_a), 32'(k == 6 || k == 12));
            check_eq($sformatf("tie busy k%0d", k),     32'(busy_a),     32'(k % 3 != 0));
            if (k == 3) check_eq("tie if_rdata", if_rdata_a, 32'h2008_0005);
            if (k == 6) check_eq("tie dm_rdata", dm_rdata_a, 32'h0000_1234);
        end
        $display("tie   both ports served alternately, 4 grants");
        if_req_a = 1'b0; dm_req_a = 1'b0;

        // ---- single fetch ----
        read_a(1'b0, 32'h0, 32'h2008_0005, "fetch0");

        // ---- store ----
        dm_req_a = 1'b1; dm_wr_a = 1'b1; dm_addr_a = 32'h40; dm_wdata_a = 32'hDEAD_BEEF;
        @(negedge Clk);
        check_eq("st gnt",    32'(dm_gnt_a),   32'd1);
        check_eq("st mem_wr", 32'(mem_wr_a),   32'd1);
        check_eq("st maddr",  mem_addr_a,      32'h40);
        check_eq("st wdata",  mem_wdata_a,     32'hDEAD_BEEF);
        check_eq("st vlo",    32'(dm_valid_a), 32'd0);
        dm_req_a = 1'b0; dm_wr_a = 1'b0;
        @(negedge Clk);
        check_eq("st wr_lo",  32'(mem_wr_a),   32'd0);
        check_eq("st valid",  32'(dm_valid_a), 32'd1);
        check_eq("st rdata",  dm_rdata_a,      32'h0000_1234);
        check_eq("st busy",   32'(busy_a),     32'd0);
        $display("store addr=00000040 data=deadbeef");
        @(negedge Clk);
        check_eq("st vdone",  32'(dm_valid_a), 32'd0);

        // ---- load back the stored word ----
        read_a(1'b1, 32'h40, 32'hDEAD_BEEF, "load40");

        // ---- fetch held continuously ----
        if_req_a = 1'b1; if_addr_a = 32'h4;
        for (int k = 1; k <= 9; k++) begin
            @(negedge Clk);
            check_eq($sformatf("hold if_gnt k%0d", k),   32'(if_gnt_a),   32'(k % 3 == 1));
            check_eq($sformatf("hold if_valid k%0d", k), 32'(if_valid_a), 32'(k % 3 == 0));
            check_eq($sformatf("hold busy k%0d", k),     32'(busy_a),     32'(k % 3 != 0));
            check_eq($sformatf("hold dm_gnt k%0d", k),   32'(dm_gnt_a),   32'd0);
            if (k == 3) check_eq("hold rdata", if_rdata_a, 32'hC0DE_0001);
        end
        $display("hold  fetch addr=00000004 granted 3 times");
        if_req_a = 1'b0;

        // ---- reset during RD_WAIT ----
        if_req_a = 1'b1; if_addr_a = 32'h4;
        @(negedge Clk);
        check_eq("ab gnt", 32'(if_gnt_a), 32'd1);
        if_req_a = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        check_eq("ab busy",   32'(busy_a),     32'd0);
        check_eq("ab mem_wr", 32'(mem_wr_a),   32'd0);
        check_eq("ab maddr",  mem_addr_a,      32'd0);
        check_eq("ab if_rd",  if_rdata_a,      32'd0);
        check_eq("ab dm_rd",  dm_rdata_a,      32'd0);
        check_eq("ab valid",  32'(if_valid_a), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            check_eq($sformatf("ab novalid %0d", k), 32'(if_valid_a), 32'd0);
        end
        Reset = 1'b1;
        $display("abort fetch aborted by reset");
        read_a(1'b0, 32'h0, 32'h2008_0005, "refetch");

        // ---- latency 1 instance: load ----
        dm_req_b = 1'b1; dm_wr_b = 1'b0; dm_addr_b = 32'h8;
        @(negedge Clk);
        check_eq("l1 gnt",   32'(dm_gnt_b),   32'd1);
        check_eq("l1 vlo",   32'(dm_valid_b), 32'd0);
        dm_req_b = 1'b0;
        @(negedge Clk);
        check_eq("l1 valid", 32'(dm_valid_b), 32'd1);
        check_eq("l1 rdata", dm_rdata_b,      32'h0000_1234);
        check_eq("l1 gnt0",  32'(dm_gnt_b),   32'd0);
        check_eq("l1 busy",  32'(busy_b),     32'd0);
        $display("read  lat1 port=DM addr=00000008 data=%08h", dm_rdata_b);
        @(negedge Clk);
        check_eq("l1 vdone", 32'(dm_valid_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
